// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns, samples synchronized rows once per
// column slot, and debounces whole-scan results into press/release events.
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    DEB_N     = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q;
  logic [11:0]   hits_q;
  state_t        state_q;
  logic [7:0]    cnt_q;
  logic [3:0]    cand_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_held_q;

  logic          sample_s, scan_end_s;
  logic [15:0]   scan_s;
  logic          none_s, single_s, match_s;
  logic [3:0]    key_s;

  // Bit index is {column, row}; returns the printed label of that key.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h4;
      4'd2:    key_map = 4'h7;
      4'd3:    key_map = 4'h0;
      4'd4:    key_map = 4'h2;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h8;
      4'd7:    key_map = 4'hF;
      4'd8:    key_map = 4'h3;
      4'd9:    key_map = 4'h6;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hE;
      4'd12:   key_map = 4'hA;
      4'd13:   key_map = 4'hB;
      4'd14:   key_map = 4'hC;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign sample_s   = (slot_q == SLOT_LAST);
  assign scan_end_s = sample_s && (col_idx_q == 2'd3);
  // Column 3 is classified straight from the synchronizer, without storing it first.
  assign scan_s     = {~row_sync_q, hits_q};
  assign none_s     = (scan_s == 16'h0000);
  assign single_s   = !none_s && ((scan_s & (scan_s - 16'd1)) == 16'h0000);
  assign match_s    = single_s && (key_s == cand_q);

  always_comb begin
    key_s = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (scan_s[i]) key_s = key_map(4'(i));
    end
  end

  always_comb begin
    if (sample_s) begin
      slot_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
    end else begin
      slot_d    = slot_q + SW'(1);
      col_idx_d = col_idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      slot_q     <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      hits_q     <= 12'h000;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      slot_q     <= slot_d;
      col_idx_q  <= col_idx_d;
      col_q      <= ~(4'b0001 << col_idx_d);
      if (sample_s) begin
        case (col_idx_q)
          2'd0:    hits_q[3:0]  <= ~row_sync_q;
          2'd1:    hits_q[7:4]  <= ~row_sync_q;
          2'd2:    hits_q[11:8] <= ~row_sync_q;
          default: hits_q       <= hits_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end_s) begin
        case (state_q)
          IDLE: begin
            if (single_s) begin
              state_q <= DEB_PRESS;
              cand_q  <= key_s;
              cnt_q   <= 8'd1;
            end
          end
          DEB_PRESS: begin
            if (match_s) begin
              if (cnt_q + 8'd1 == DEB_N) begin
                state_q     <= PRESSED;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= 8'd0;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= 8'd0;
            end
          end
          PRESSED: begin
            if (!match_s) begin
              state_q <= DEB_RELEASE;
              cnt_q   <= 8'd1;
            end
          end
          default: begin
            if (none_s) begin
              if (cnt_q + 8'd1 == DEB_N) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= 8'd0;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else if (match_s) begin
              state_q <= PRESSED;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= 8'd0;
            end
          end
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad (Pmod KYPD layout) and reports debounced key presses as 4-bit hex codes. It is the input-side counterpart of the board's four-digit seven-segment display path: the display drives multiplexed outputs, and this block drives multiplexed column strobes and reads rows back. Its `key_code`/`key_valid` outputs feed the digit registers that supply the display's `in0..in3`.

## Interface
- `SCAN_DIV`, default 25000 — clock cycles per column slot (250 us at 100 MHz, so one full scan takes 1 ms); legal range 4..2^20.
- `DEBOUNCE_SCANS`, default 10 — number of consecutive identical full-scan results needed to accept a press or a release; legal range 2..255.
- `clk`, input, 1 — system clock, 100 MHz on Basys3.
- `reset`, input, 1 — asynchronous, active-high reset.
- `row`, input, 4 — keypad row lines, active-low, pulled up on the board, asynchronous to `clk`.
- `col`, output, 4 — column strobes, active-low, exactly one bit low at all times.
- `key_code`, output, 4 — hex value of the last accepted key; held until the next accept.
- `key_valid`, output, 1 — one-cycle pulse when a new press is accepted.
- `key_held`, output, 1 — high from press acceptance until release acceptance.

## Operation
- **Row input:** `row` passes through a 2-flop synchronizer before any use.
- **Slot counter:** `slot_cnt` runs 0..SCAN_DIV-1, then wraps; on wrap the column index advances 0→1→2→3→0.
- **Column drive:** `col` = ~(1 << column index). The column index is registered.
- **Sampling:** the synchronized rows are sampled on the cycle where `slot_cnt` == SCAN_DIV-1. This gives at least SCAN_DIV-2 cycles of settling after the column change.
- **Key map** (row r, col c, label = code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- **Scan result:** a full scan is the 16 samples from col0 through col3. It is classified at the col3 sample cycle (the "scan-end" cycle) as one of:
  - NONE — no row low in any column.
  - SINGLE(k) — exactly one row/column intersection low.
  - MULTI — two or more intersections low.
- **FSM** (evaluated only on scan-end cycles; `cnt` is 8 bits):
  - **IDLE:**
    - SINGLE(k) → DEB_PRESS, `cand`=k, `cnt`=1.
    - Otherwise stay.
  - **DEB_PRESS:**
    - SINGLE(`cand`) → `cnt`+1. When `cnt`+1 == DEBOUNCE_SCANS → PRESSED, `key_code`=`cand`, `key_valid` pulses, `key_held`=1, `cnt`=0.
    - NONE, MULTI, or SINGLE(other) → IDLE, `cnt`=0. No event.
  - **PRESSED:**
    - SINGLE(`cand`) → stay.
    - Anything else → DEB_RELEASE, `cnt`=1.
  - **DEB_RELEASE:**
    - NONE → `cnt`+1. When `cnt`+1 == DEBOUNCE_SCANS → IDLE, `key_held`=0.
    - SINGLE(`cand`) → PRESSED, `cnt`=0. No new `key_valid`.
    - MULTI or SINGLE(other) → stay, `cnt`=0.
- **No auto-repeat:** a key held indefinitely produces exactly one `key_valid`.
- **Rollover:** a second key pressed while one is held is ignored until a clean release completes.

## Timing
- **Reset values** (all take effect immediately on `reset` high):
  - `col` = 4'b1110, column index = 0, `slot_cnt` = 0.
  - FSM = IDLE, `cnt` = 0, `cand` = 0.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0.
- **Reset mid-operation:** any pending candidate or release is discarded. No `key_valid` is generated by or after reset until a full new debounce completes.
- **Output timing:** all outputs are registered. `key_valid`, `key_code` and `key_held` change in the cycle after the accepting scan-end cycle. `key_valid` is high for exactly 1 cycle.
- **Press latency:** from a stable press to `key_valid` is between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scan periods (scan period = 4·SCAN_DIV cycles), plus 1 cycle.
- **Release latency:** `key_held` falls DEBOUNCE_SCANS consecutive NONE scans after the first non-matching scan, plus 1 cycle.
- **Column timing:** the `col` change and the `slot_cnt` wrap occur on the same edge. Scans are continuous, with no gap between col3 and col0.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a 16-cycle scan.
1. Reset, then run 32 cycles → all outputs 0 during reset; `col` sequence 1110, 1101, 1011, 0111 with each value lasting 4 cycles, repeating; no `key_valid`.
2. Model key '5' (row1 low while col1 low) held for 6 scans → exactly one `key_valid` pulse, `key_code`=4'h5, `key_held`=1 from the third complete matching scan-end +1 cycle.
3. Key 'A' present for 2 scans, absent for 1, then held → no `key_valid` from the first burst; one pulse with `key_code`=4'hA after 3 further consecutive matching scans.
4. After '5' is accepted: release for 2 scans, press again for 1 scan, then release for 3 scans → `key_held` stays 1 through the bounce and no new `key_valid`; `key_held` falls after the third consecutive NONE scan.
5. Keys '1' and '2' pressed simultaneously for 5 scans → no `key_valid`; `key_code` keeps its prior value; FSM stays IDLE.
6. Assert `reset` during DEB_PRESS for key 'D' (after 2 matching scans), release `reset` with the key still held → no early pulse; `key_valid` with `key_code`=4'hD only after 3 full post-reset scans.
